// File: rtl/hd_transfer_controller.sv
// Initiator-side block-transfer controller for the track/sector hard-drive model.
// Moves a run of consecutive 32-bit words between the drive and main memory,
// one word per clock, in either direction, then pulses done for one cycle.
module hd_transfer_controller #(
    parameter int TRACK_COUNT  = 128,
    parameter int SECTOR_COUNT = 16384,
    parameter int MEM_ADDR_W   = 10,
    parameter int LEN_W        = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_start,
    input  logic                  cmd_dir,
    input  logic [6:0]            cmd_track,
    input  logic [13:0]           cmd_sector,
    input  logic [MEM_ADDR_W-1:0] cmd_mem_addr,
    input  logic [LEN_W-1:0]      cmd_length,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [LEN_W-1:0]      xfer_count,
    output logic [6:0]            track,
    output logic [13:0]           sector,
    output logic [31:0]           data_write,
    output logic                  flag_write_hd,
    input  logic [31:0]           output_hard_drive,
    output logic [MEM_ADDR_W-1:0] mem_addr,
    output logic [31:0]           mem_data_write,
    output logic                  mem_write_enable,
    input  logic [31:0]           mem_data_read
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_STORE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Last valid drive coordinates; reaching them makes the address wrap.
    localparam logic [6:0]  TRACK_LAST  = 7'(TRACK_COUNT - 1);
    localparam logic [13:0] SECTOR_LAST = 14'(SECTOR_COUNT - 1);

    state_t                  state_q, state_d;
    logic [6:0]              track_q, track_d;
    logic [13:0]             sector_q, sector_d;
    logic [MEM_ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [LEN_W-1:0]        remain_q, remain_d;
    logic [LEN_W-1:0]        xfer_count_q, xfer_count_d;
    logic                    error_q, error_d;

    logic                    cmd_in_range;
    logic [6:0]              track_next;
    logic [13:0]             sector_next;

    // Command address check against the configured drive geometry.
    always_comb begin
        cmd_in_range = (32'(cmd_track) < 32'(TRACK_COUNT)) &&
                       (32'(cmd_sector) < 32'(SECTOR_COUNT));
    end

    // Next drive address: sector-major, carrying into the track and wrapping at the end of the drive.
    always_comb begin
        track_next  = track_q;
        sector_next = sector_q + 14'd1;
        if (sector_q == SECTOR_LAST) begin
            sector_next = 14'd0;
            if (track_q == TRACK_LAST) begin
                track_next = 7'd0;
            end else begin
                track_next = track_q + 7'd1;
            end
        end
    end

    // State and datapath registers; asynchronous reset clears everything so strobes drop at once.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            track_q      <= 7'd0;
            sector_q     <= 14'd0;
            mem_addr_q   <= '0;
            remain_q     <= '0;
            xfer_count_q <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            track_q      <= track_d;
            sector_q     <= sector_d;
            mem_addr_q   <= mem_addr_d;
            remain_q     <= remain_d;
            xfer_count_q <= xfer_count_d;
            error_q      <= error_d;
        end
    end

    // Next-state and register update: command acceptance in IDLE, one word per cycle while transferring.
    always_comb begin
        state_d      = state_q;
        track_d      = track_q;
        sector_d     = sector_q;
        mem_addr_d   = mem_addr_q;
        remain_d     = remain_q;
        xfer_count_d = xfer_count_q;
        error_d      = error_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_start) begin
                    xfer_count_d = '0;
                    if (!cmd_in_range) begin
                        // Rejected: report through the sticky error flag, no strobes.
                        error_d = 1'b1;
                        state_d = ST_DONE;
                    end else if (cmd_length == '0) begin
                        // Empty but legal: completes immediately without error.
                        error_d = 1'b0;
                        state_d = ST_DONE;
                    end else begin
                        error_d    = 1'b0;
                        track_d    = cmd_track;
                        sector_d   = cmd_sector;
                        mem_addr_d = cmd_mem_addr;
                        remain_d   = cmd_length;
                        state_d    = cmd_dir ? ST_STORE : ST_LOAD;
                    end
                end
            end
            ST_LOAD, ST_STORE: begin
                xfer_count_d = xfer_count_q + LEN_W'(1);
                remain_d     = remain_q - LEN_W'(1);
                mem_addr_d   = mem_addr_q + MEM_ADDR_W'(1);
                track_d      = track_next;
                sector_d     = sector_next;
                if (remain_q == LEN_W'(1)) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Outputs decoded from state; data paths are gated so strobe and data are valid in the same cycle.
    always_comb begin
        busy             = (state_q != ST_IDLE);
        done             = (state_q == ST_DONE);
        error            = error_q;
        xfer_count       = xfer_count_q;
        track            = track_q;
        sector           = sector_q;
        mem_addr         = mem_addr_q;
        mem_write_enable = 1'b0;
        mem_data_write   = 32'd0;
        flag_write_hd    = 1'b0;
        data_write       = 32'd0;
        if (state_q == ST_LOAD) begin
            mem_write_enable = 1'b1;
            mem_data_write   = output_hard_drive;
        end
        if (state_q == ST_STORE) begin
            flag_write_hd = 1'b1;
            data_write    = mem_data_read;
        end
    end

endmodule

// File: tb/tb_hd_transfer_controller.sv
// Bench for hd_transfer_controller on a small 4-track x 4-sector drive model
// with a 1K-word memory model. Every strobed word is logged with its cycle and
// compared against a queue of expected words built when each command is issued.
module tb_hd_transfer_controller;

    localparam int TC = 4;
    localparam int SC = 4;
    localparam int AW = 10;
    localparam int LW = 16;

    typedef struct packed {
        logic [1:0]  kind;    // {flag_write_hd, mem_write_enable}
        logic [31:0] cyc;
        logic [6:0]  track;
        logic [13:0] sector;
        logic [9:0]  addr;
        logic [31:0] data;
    } ev_t;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          cmd_start = 1'b0;
    logic          cmd_dir = 1'b0;
    logic [6:0]    cmd_track = '0;
    logic [13:0]   cmd_sector = '0;
    logic [AW-1:0] cmd_mem_addr = '0;
    logic [LW-1:0] cmd_length = '0;
    logic          busy, done, error;
    logic [LW-1:0] xfer_count;
    logic [6:0]    track;
    logic [13:0]   sector;
    logic [31:0]   data_write;
    logic          flag_write_hd;
    logic [31:0]   output_hard_drive;
    logic [AW-1:0] mem_addr;
    logic [31:0]   mem_data_write;
    logic          mem_write_enable;
    logic [31:0]   mem_data_read;

    logic [31:0]   mem [0:1023];
    logic [31:0]   drv [0:15];
    logic          poke_mem_en = 1'b0;
    logic          poke_drv_en = 1'b0;
    logic [9:0]    poke_maddr = '0;
    logic [3:0]    poke_didx = '0;
    logic [31:0]   poke_data = '0;

    int            cyc = 0;
    ev_t           obs [0:255];
    int            obs_n = 0;
    int            obs_rd = 0;
    ev_t           exp_q [$];
    int            checks = 0;
    int            failures = 0;

    hd_transfer_controller #(
        .TRACK_COUNT(TC), .SECTOR_COUNT(SC), .MEM_ADDR_W(AW), .LEN_W(LW)
    ) dut (
        .clock(clock), .reset(reset),
        .cmd_start(cmd_start), .cmd_dir(cmd_dir), .cmd_track(cmd_track),
        .cmd_sector(cmd_sector), .cmd_mem_addr(cmd_mem_addr), .cmd_length(cmd_length),
        .busy(busy), .done(done), .error(error), .xfer_count(xfer_count),
        .track(track), .sector(sector), .data_write(data_write),
        .flag_write_hd(flag_write_hd), .output_hard_drive(output_hard_drive),
        .mem_addr(mem_addr), .mem_data_write(mem_data_write),
        .mem_write_enable(mem_write_enable), .mem_data_read(mem_data_read)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Drive and memory models: combinational read, write on the rising edge.
    assign output_hard_drive = (track < 7'd4 && sector < 14'd4) ?
                               drv[{track[1:0], sector[1:0]}] : 32'hBAD0BAD0;
    assign mem_data_read = mem[mem_addr];

    always @(posedge clock) begin
        if (poke_mem_en) mem[poke_maddr] <= poke_data;
        else if (mem_write_enable) mem[mem_addr] <= mem_data_write;
    end

    always @(posedge clock) begin
        if (poke_drv_en) drv[poke_didx] <= poke_data;
        else if (flag_write_hd && track < 7'd4 && sector < 14'd4)
            drv[{track[1:0], sector[1:0]}] <= data_write;
    end

    // Log every strobed word mid-cycle.
    always @(negedge clock) begin
        if ((mem_write_enable || flag_write_hd) && obs_n < 256) begin
            obs[obs_n] <= '{kind: {flag_write_hd, mem_write_enable}, cyc: 32'(cyc),
                            track: track, sector: sector, addr: mem_addr,
                            data: mem_write_enable ? mem_data_write : data_write};
            obs_n <= obs_n + 1;
        end
    end

    task automatic poke_mem(input logic [9:0] a, input logic [31:0] d);
        @(negedge clock);
        poke_mem_en = 1'b1; poke_maddr = a; poke_data = d;
        @(posedge clock); #1;
        poke_mem_en = 1'b0;
    endtask

    task automatic poke_drv(input int t, input int s, input logic [31:0] d);
        @(negedge clock);
        poke_drv_en = 1'b1; poke_didx = 4'(t * SC + s); poke_data = d;
        @(posedge clock); #1;
        poke_drv_en = 1'b0;
    endtask

    // Pulse cmd_start for one edge; s is the cycle number right after that edge.
    task automatic issue(input logic dir, input logic [6:0] t, input logic [13:0] sc,
                         input logic [9:0] a, input logic [15:0] n, output int s);
        @(negedge clock);
        cmd_dir = dir; cmd_track = t; cmd_sector = sc; cmd_mem_addr = a; cmd_length = n;
        cmd_start = 1'b1;
        @(posedge clock); #1;
        cmd_start = 1'b0;
        s = cyc;
    endtask

    // Reference model: expected word k appears in cycle s+k at the advancing addresses.
    task automatic push_exp(input logic dir, input logic [6:0] t, input logic [13:0] sc,
                            input logic [9:0] a, input int n, input int s);
        ev_t e;
        for (int k = 0; k < n; k++) begin
            e.kind   = dir ? 2'b10 : 2'b01;
            e.cyc    = 32'(s + k);
            e.track  = t;
            e.sector = sc;
            e.addr   = a;
            e.data   = dir ? mem[a] : drv[int'(t) * SC + int'(sc)];
            exp_q.push_back(e);
            if (int'(sc) == SC - 1) begin
                sc = 14'd0;
                t  = (int'(t) == TC - 1) ? 7'd0 : t + 7'd1;
            end else begin
                sc = sc + 14'd1;
            end
            a = a + 10'd1;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if ({busy, done, error, flag_write_hd, mem_write_enable} !== 5'b0) begin
            failures++;
            $display("FAIL reset_ctrl got=%b want=00000", {busy, done, error, flag_write_hd, mem_write_enable});
        end
        checks++;
        if ({xfer_count, track, sector, mem_addr} !== '0) begin
            failures++;
            $display("FAIL reset_addr xfer=%0d trk=%0d sec=%0d maddr=%0d want all 0", xfer_count, track, sector, mem_addr);
        end
        checks++;
        if ({data_write, mem_data_write} !== 64'd0) begin
            failures++;
            $display("FAIL reset_data dw=%h mdw=%h want 0", data_write, mem_data_write);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_load_basic();
        int s;
        bit got;
        for (int i = 0; i < 3; i++) poke_drv(0, i, 32'hA000_0000 + 32'(i));
        issue(1'b0, 7'd0, 14'd0, 10'd0, 16'd3, s);
        push_exp(1'b0, 7'd0, 14'd0, 10'd0, 3, s);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) begin got = 1; break; end
        end
        checks++;
        if (!got || cyc != s + 3) begin
            failures++;
            $display("FAIL load_done_cycle got=%0d want=%0d seen=%0d", cyc - s, 3, got);
        end
        checks++;
        if ({busy, error, xfer_count} !== {1'b1, 1'b0, 16'd3}) begin
            failures++;
            $display("FAIL load_done_state busy=%b err=%b xfer=%0d want 1 0 3", busy, error, xfer_count);
        end
        @(negedge clock);
        checks++;
        if ({done, busy} !== 2'b00) begin
            failures++;
            $display("FAIL load_idle done=%b busy=%b want 0 0", done, busy);
        end
        checks++;
        if (obs_n - obs_rd != exp_q.size()) begin
            failures++;
            $display("FAIL load_word_count got=%0d want=%0d", obs_n - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_n) begin
            ev_t e, o;
            e = exp_q.pop_front(); o = obs[obs_rd]; obs_rd++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL load_word got k=%b c=%0d t=%0d s=%0d a=%0d d=%h want k=%b c=%0d t=%0d s=%0d a=%0d d=%h",
                         o.kind, o.cyc, o.track, o.sector, o.addr, o.data, e.kind, e.cyc, e.track, e.sector, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_rd = obs_n;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (mem[i] !== 32'hA000_0000 + 32'(i)) begin
                failures++;
                $display("FAIL load_mem[%0d] got=%h want=%h", i, mem[i], 32'hA000_0000 + 32'(i));
            end
        end
    endtask

    task automatic test_store_basic();
        int s;
        bit got;
        poke_mem(10'd5, 32'hDEADBEEF);
        poke_mem(10'd6, 32'h12345678);
        issue(1'b1, 7'd2, 14'd1, 10'd5, 16'd2, s);
        push_exp(1'b1, 7'd2, 14'd1, 10'd5, 2, s);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) begin got = 1; break; end
        end
        checks++;
        if (!got || cyc != s + 2 || xfer_count !== 16'd2) begin
            failures++;
            $display("FAIL store_done cycle=%0d xfer=%0d want cycle=2 xfer=2", cyc - s, xfer_count);
        end
        @(negedge clock);
        checks++;
        if (obs_n - obs_rd != exp_q.size()) begin
            failures++;
            $display("FAIL store_word_count got=%0d want=%0d", obs_n - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_n) begin
            ev_t e, o;
            e = exp_q.pop_front(); o = obs[obs_rd]; obs_rd++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL store_word got k=%b c=%0d t=%0d s=%0d a=%0d d=%h want k=%b c=%0d t=%0d s=%0d a=%0d d=%h",
                         o.kind, o.cyc, o.track, o.sector, o.addr, o.data, e.kind, e.cyc, e.track, e.sector, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_rd = obs_n;
        checks++;
        if ({drv[2*SC+1], drv[2*SC+2]} !== {32'hDEADBEEF, 32'h12345678}) begin
            failures++;
            $display("FAIL store_drive got=%h,%h want=deadbeef,12345678", drv[2*SC+1], drv[2*SC+2]);
        end
    endtask

    task automatic test_sector_wrap();
        int s;
        bit got;
        poke_drv(1, 2, 32'hB102_0000);
        poke_drv(1, 3, 32'hB103_0000);
        poke_drv(2, 0, 32'hB200_0000);
        poke_drv(2, 1, 32'hB201_0000);
        issue(1'b0, 7'd1, 14'd2, 10'd20, 16'd4, s);
        push_exp(1'b0, 7'd1, 14'd2, 10'd20, 4, s);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) begin got = 1; break; end
        end
        checks++;
        if (!got || cyc != s + 4) begin
            failures++;
            $display("FAIL swrap_done_cycle got=%0d want=4 seen=%0d", cyc - s, got);
        end
        @(negedge clock);
        checks++;
        if (obs_n - obs_rd != exp_q.size()) begin
            failures++;
            $display("FAIL swrap_word_count got=%0d want=%0d", obs_n - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_n) begin
            ev_t e, o;
            e = exp_q.pop_front(); o = obs[obs_rd]; obs_rd++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL swrap_word got k=%b c=%0d t=%0d s=%0d a=%0d d=%h want k=%b c=%0d t=%0d s=%0d a=%0d d=%h",
                         o.kind, o.cyc, o.track, o.sector, o.addr, o.data, e.kind, e.cyc, e.track, e.sector, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_rd = obs_n;
        checks++;
        if (mem[22] !== 32'hB200_0000 || mem[23] !== 32'hB201_0000) begin
            failures++;
            $display("FAIL swrap_mem got=%h,%h want=b2000000,b2010000", mem[22], mem[23]);
        end
    endtask

    task automatic test_track_wrap();
        int s;
        bit got;
        poke_mem(10'd50, 32'h3333_0003);
        poke_mem(10'd51, 32'h0000_0A0A);
        issue(1'b1, 7'd3, 14'd3, 10'd50, 16'd2, s);
        push_exp(1'b1, 7'd3, 14'd3, 10'd50, 2, s);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) begin got = 1; break; end
        end
        checks++;
        if (!got || cyc != s + 2) begin
            failures++;
            $display("FAIL twrap_done_cycle got=%0d want=2 seen=%0d", cyc - s, got);
        end
        @(negedge clock);
        checks++;
        if (obs_n - obs_rd != exp_q.size()) begin
            failures++;
            $display("FAIL twrap_word_count got=%0d want=%0d", obs_n - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_n) begin
            ev_t e, o;
            e = exp_q.pop_front(); o = obs[obs_rd]; obs_rd++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL twrap_word got k=%b c=%0d t=%0d s=%0d a=%0d d=%h want k=%b c=%0d t=%0d s=%0d a=%0d d=%h",
                         o.kind, o.cyc, o.track, o.sector, o.addr, o.data, e.kind, e.cyc, e.track, e.sector, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_rd = obs_n;
        checks++;
        if (drv[15] !== 32'h3333_0003 || drv[0] !== 32'h0000_0A0A) begin
            failures++;
            $display("FAIL twrap_drive got=%h,%h want=33330003,00000a0a", drv[15], drv[0]);
        end
    endtask

    task automatic test_invalid_empty();
        int s;
        int n0;
        n0 = obs_n;
        // Sector out of range: rejected.
        issue(1'b0, 7'd0, 14'(SC), 10'd0, 16'd3, s);
        @(negedge clock);
        checks++;
        if ({done, busy, error} !== 3'b111) begin
            failures++;
            $display("FAIL bad_sector done=%b busy=%b err=%b want 1 1 1", done, busy, error);
        end
        @(negedge clock);
        checks++;
        if ({done, busy, error} !== 3'b001) begin
            failures++;
            $display("FAIL bad_sticky done=%b busy=%b err=%b want 0 0 1", done, busy, error);
        end
        // Zero length: accepted, empty.
        issue(1'b1, 7'd1, 14'd1, 10'd0, 16'd0, s);
        @(negedge clock);
        checks++;
        if ({done, busy, error} !== 3'b110) begin
            failures++;
            $display("FAIL zero_len done=%b busy=%b err=%b want 1 1 0", done, busy, error);
        end
        // Track out of range, then a valid start clears the error.
        issue(1'b0, 7'(TC), 14'd0, 10'd0, 16'd1, s);
        @(negedge clock);
        checks++;
        if ({done, error} !== 2'b11) begin
            failures++;
            $display("FAIL bad_track done=%b err=%b want 1 1", done, error);
        end
        @(negedge clock);
        checks++;
        if (obs_n !== n0) begin
            failures++;
            $display("FAIL reject_strobes got=%0d words want=0", obs_n - n0);
        end
        issue(1'b0, 7'd0, 14'd0, 10'd600, 16'd1, s);
        @(negedge clock);
        checks++;
        if ({mem_write_enable, error} !== 2'b10) begin
            failures++;
            $display("FAIL err_clear we=%b err=%b want 1 0", mem_write_enable, error);
        end
        repeat (2) @(negedge clock);
        obs_rd = obs_n;
    endtask

    task automatic test_busy_ignore();
        int s;
        bit got;
        poke_drv(3, 0, 32'hC300_0000);
        poke_drv(3, 1, 32'hC301_0000);
        poke_drv(3, 2, 32'hC302_0000);
        issue(1'b0, 7'd3, 14'd0, 10'd100, 16'd3, s);
        push_exp(1'b0, 7'd3, 14'd0, 10'd100, 3, s);
        @(negedge clock);
        cmd_dir = 1'b1; cmd_track = 7'd0; cmd_sector = 14'd0; cmd_mem_addr = 10'd200; cmd_length = 16'd1;
        cmd_start = 1'b1;
        @(posedge clock); #1;
        cmd_start = 1'b0;
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) begin got = 1; break; end
        end
        checks++;
        if (!got || cyc != s + 3 || xfer_count !== 16'd3) begin
            failures++;
            $display("FAIL busy_done cycle=%0d xfer=%0d want cycle=3 xfer=3", cyc - s, xfer_count);
        end
        @(negedge clock);
        @(negedge clock);
        checks++;
        if (obs_n - obs_rd != exp_q.size()) begin
            failures++;
            $display("FAIL busy_word_count got=%0d want=%0d", obs_n - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_n) begin
            ev_t e, o;
            e = exp_q.pop_front(); o = obs[obs_rd]; obs_rd++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL busy_word got k=%b c=%0d t=%0d s=%0d a=%0d d=%h want k=%b c=%0d t=%0d s=%0d a=%0d d=%h",
                         o.kind, o.cyc, o.track, o.sector, o.addr, o.data, e.kind, e.cyc, e.track, e.sector, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_rd = obs_n;
    endtask

    task automatic test_reset_mid_store();
        int s;
        bit got;
        for (int i = 0; i < 5; i++) poke_mem(10'(300 + i), 32'h5000_0000 + 32'(i));
        poke_drv(1, 0, 32'h1010_0000);
        poke_drv(1, 1, 32'h1111_0000);
        poke_drv(0, 3, 32'h0303_0303);
        issue(1'b1, 7'd1, 14'd0, 10'd300, 16'd5, s);
        push_exp(1'b1, 7'd1, 14'd0, 10'd300, 2, s);
        @(negedge clock);
        @(negedge clock);
        #2 reset = 1'b1;
        #1;
        checks++;
        if ({flag_write_hd, busy, xfer_count} !== {1'b0, 1'b0, 16'd0}) begin
            failures++;
            $display("FAIL mid_reset fwh=%b busy=%b xfer=%0d want 0 0 0", flag_write_hd, busy, xfer_count);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        checks++;
        if (obs_n - obs_rd != exp_q.size()) begin
            failures++;
            $display("FAIL mid_word_count got=%0d want=%0d", obs_n - obs_rd, exp_q.size());
        end
        while (exp_q.size() > 0 && obs_rd < obs_n) begin
            ev_t e, o;
            e = exp_q.pop_front(); o = obs[obs_rd]; obs_rd++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL mid_word got k=%b c=%0d t=%0d s=%0d a=%0d d=%h want k=%b c=%0d t=%0d s=%0d a=%0d d=%h",
                         o.kind, o.cyc, o.track, o.sector, o.addr, o.data, e.kind, e.cyc, e.track, e.sector, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_rd = obs_n;
        checks++;
        if (drv[1*SC+0] !== 32'h5000_0000 || drv[1*SC+1] !== 32'h1111_0000) begin
            failures++;
            $display("FAIL mid_drive got=%h,%h want=50000000,11110000", drv[1*SC+0], drv[1*SC+1]);
        end
        // Fresh command after reset: load (0,3),(1,0) into memory 400..401.
        issue(1'b0, 7'd0, 14'd3, 10'd400, 16'd2, s);
        push_exp(1'b0, 7'd0, 14'd3, 10'd400, 2, s);
        got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clock);
            if (done) begin got = 1; break; end
        end
        checks++;
        if (!got || cyc != s + 2 || xfer_count !== 16'd2) begin
            failures++;
            $display("FAIL post_reset_done cycle=%0d xfer=%0d want cycle=2 xfer=2", cyc - s, xfer_count);
        end
        @(negedge clock);
        while (exp_q.size() > 0 && obs_rd < obs_n) begin
            ev_t e, o;
            e = exp_q.pop_front(); o = obs[obs_rd]; obs_rd++;
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL post_reset_word got k=%b c=%0d t=%0d s=%0d a=%0d d=%h want k=%b c=%0d t=%0d s=%0d a=%0d d=%h",
                         o.kind, o.cyc, o.track, o.sector, o.addr, o.data, e.kind, e.cyc, e.track, e.sector, e.addr, e.data);
            end
        end
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL post_reset_missing got=%0d words left want=0", exp_q.size());
        end
        exp_q.delete(); obs_rd = obs_n;
        checks++;
        if (mem[400] !== 32'h0303_0303 || mem[401] !== 32'h5000_0000) begin
            failures++;
            $display("FAIL post_reset_mem got=%h,%h want=03030303,50000000", mem[400], mem[401]);
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_load_basic();
        test_store_basic();
        test_sector_wrap();
        test_track_wrap();
        test_invalid_empty();
        test_busy_ignore();
        test_reset_mid_store();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hd_transfer_controller.md
Name: hd_transfer_controller

Overview:
Initiator-side controller for the track/sector hard-drive model. It accepts a block-transfer command from the CPU and sequences track, sector, data_write and flag_write_hd toward the drive. It moves N consecutive 32-bit words in either direction between the drive and main memory (drive-to-memory for program loading, memory-to-drive for storing). It sits between the CPU I/O decode and the harddrive/memory instances.

Parameters:
TRACK_COUNT, 128, number of valid tracks (track indices 0..TRACK_COUNT-1)
SECTOR_COUNT, 16384, words per track (sector indices 0..SECTOR_COUNT-1)
MEM_ADDR_W, 10, main-memory word address width
LEN_W, 16, width of transfer length field

Ports:
clock  in  1  system clock, rising-edge
reset  in  1  asynchronous, active-high reset
cmd_start  in  1  one-cycle command strobe
cmd_dir  in  1  0 = drive-to-memory (load), 1 = memory-to-drive (store)
cmd_track  in  7  starting track
cmd_sector  in  14  starting sector
cmd_mem_addr  in  MEM_ADDR_W  starting memory word address
cmd_length  in  LEN_W  number of words to move
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
error  out  1  sticky: last command rejected; cleared by next accepted start
xfer_count  out  LEN_W  words moved by the current/last command
track  out  7  to drive
sector  out  14  to drive
data_write  out  32  to drive
flag_write_hd  out  1  drive write strobe
output_hard_drive  in  32  drive read data (combinational in track/sector)
mem_addr  out  MEM_ADDR_W  memory address
mem_data_write  out  32  memory write data
mem_write_enable  out  1  memory write strobe
mem_data_read  in  32  memory read data (combinational in mem_addr)

Behaviour:
- Reset is asynchronous and active-high. Port names are clock and reset. On reset: state IDLE; busy, done, error, flag_write_hd and mem_write_enable are 0; xfer_count, track, sector and mem_addr are 0; data_write and mem_data_write are 0.
- A reset mid-transfer drops both write strobes immediately, without waiting for a clock edge. Partially written words stay written.
- States: IDLE, LOAD (drive to memory), STORE (memory to drive), DONE.
- IDLE: cmd_start is sampled at a rising edge.
  - If cmd_track >= TRACK_COUNT or cmd_sector >= SECTOR_COUNT: go to DONE with error=1. No strobes are issued.
  - Else if cmd_length == 0: go to DONE with error=0. No strobes are issued.
  - Else: latch the addresses, load the remaining count with cmd_length, clear xfer_count and error, and go to LOAD or STORE per cmd_dir.
- cmd_start is ignored while busy. The command inputs are only sampled in IDLE.
- LOAD: one word per cycle.
  - mem_write_enable=1, mem_addr=current memory address, mem_data_write=output_hard_drive, with track/sector driven with the current drive address.
- STORE: one word per cycle.
  - flag_write_hd=1, data_write=mem_data_read, with mem_addr driven with the current memory address.
- Outputs in LOAD/STORE are combinational from state and registered addresses, so data and strobe are valid in the same cycle.
- At each transfer edge: xfer_count+1, remaining count-1, mem_addr+1 (wraps modulo 2^MEM_ADDR_W), and the drive address advances.
  - Drive address advance: sector+1. If sector == SECTOR_COUNT-1, sector becomes 0 and track+1. If track == TRACK_COUNT-1 as well, track becomes 0.
- When the remaining count reaches 0 (after the last word), go to DONE.
- DONE: lasts exactly 1 cycle with done=1, busy=1 and no strobes. Then IDLE.
- busy=1 in LOAD, STORE and DONE.
- Latency: start at edge 0 gives transfer cycles 1..N, done in cycle N+1, and IDLE again from cycle N+2.
- In IDLE and DONE, track/sector/mem_addr hold their last values and both strobes are 0.

Test Plan:
- Reset, then LOAD track 0, sector 0, mem_addr 0, length 3, with drive contents A0,A1,A2 -> mem_write_enable high exactly cycles 1-3; memory[0..2]=A0..A2; done pulse in cycle 4; xfer_count=3; flag_write_hd never high.
- STORE mem_addr 5, track 2, sector 1, length 2, with memory[5]=0xDEADBEEF and memory[6]=0x12345678 -> drive[2][1]=0xDEADBEEF, drive[2][2]=0x12345678; flag_write_hd high exactly 2 cycles.
- SECTOR_COUNT=4: LOAD from track 1, sector 2, length 4 -> drive addresses (1,2),(1,3),(2,0),(2,1).
- Track wrap: TRACK_COUNT=4, SECTOR_COUNT=4, STORE from track 3, sector 3, length 2 -> drive writes go to (3,3) then (0,0).
- Invalid or empty commands:
  - cmd_sector = SECTOR_COUNT -> done next cycle with error=1 and no strobes.
  - cmd_length=0 -> done next cycle with error=0 and no strobes.
  - A subsequent valid start -> error cleared.
- Second cmd_start during busy -> ignored, first transfer completes unchanged.
- Reset asserted mid-STORE in cycle 2 of length 5 -> flag_write_hd=0 immediately; busy=0; after reset release, a new command runs normally.
